// File: rtl/ram_resp.sv
// ram_resp: single-port word store answering read requests after a fixed
// latency and acknowledging writes, with protocol-violation flagging and
// per-frame request counters cleared by SOF.
module ram_resp #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 3      // legal 2..15; the 4-bit latency counter holds RD_LAT-2
) (
    input  logic              clk_fast,
    input  logic              reset,
    input  logic              SOF,
    input  logic              rd_r,
    input  logic              wr_r,
    input  logic [ADDR_W-1:0] addrsam_r,
    input  logic [ADDR_W-1:0] addrjpeg_r,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              WR_DATAFlag,
    output logic              busy,
    output logic              err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_ACK} state_t;

    // RD_WAIT spans RD_LAT-2 decrements plus the zero-detect cycle, then
    // RD_DONE registers the data: RD_LAT edges from request to rd_valid.
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 2);

    state_t              state;
    logic [3:0]          lat_cnt;
    logic [MEM_AW-1:0]   rd_addr;
    logic [DATA_W-1:0]   mem [2**MEM_AW];

    logic idle;
    logic rd_acc;
    logic wr_acc;
    logic viol;

    // Write wins a collision; any strobe while busy is dropped and flagged.
    assign idle   = (state == IDLE);
    assign wr_acc = idle & wr_r;
    assign rd_acc = idle & rd_r & ~wr_r;
    assign viol   = (idle & rd_r & wr_r) | (~idle & (rd_r | wr_r));

    // Upper address bits alias and are intentionally unused.
    generate
        if (ADDR_W > MEM_AW) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^{addrsam_r[ADDR_W-1:MEM_AW], addrjpeg_r[ADDR_W-1:MEM_AW]};
        end
    endgenerate

    // Storage: no reset so contents survive it; write lands on the sampling edge.
    always_ff @(posedge clk_fast) begin
        if (wr_acc && !reset)
            mem[addrjpeg_r[MEM_AW-1:0]] <= wr_data;
    end

    // Request FSM with registered outputs; reset aborts any in-flight access.
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            rd_addr     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            WR_DATAFlag <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            rd_valid    <= 1'b0;
            WR_DATAFlag <= 1'b0;
            err         <= viol;
            case (state)
                IDLE: begin
                    if (wr_r) begin
                        state <= WR_ACK;
                        busy  <= 1'b1;
                    end else if (rd_r) begin
                        rd_addr <= addrsam_r[MEM_AW-1:0];
                        lat_cnt <= LAT_INIT;
                        state   <= RD_WAIT;
                        busy    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd0)
                        state <= RD_DONE;
                    else
                        lat_cnt <= lat_cnt - 4'd1;
                end
                RD_DONE: begin
                    rd_data  <= mem[rd_addr];
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                WR_ACK: begin
                    WR_DATAFlag <= 1'b1;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-frame counters: SOF restarts from 0, or from 1 if a request lands with it.
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (SOF) begin
            rd_count <= {15'd0, rd_acc};
            wr_count <= {15'd0, wr_acc};
        end else begin
            if (rd_acc) rd_count <= rd_count + 16'd1;
            if (wr_acc) wr_count <= wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ram_resp.sv
// Directed bench for ram_resp: write/read, aliasing, collision, busy
// violation, SOF counter restart and reset mid-read.
module tb_ram_resp;

    logic        clk_fast = 1'b0;
    logic        reset;
    logic        SOF;
    logic        rd_r;
    logic        wr_r;
    logic [22:0] addrsam_r;
    logic [22:0] addrjpeg_r;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        WR_DATAFlag;
    logic        busy;
    logic        err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int errors = 0;
    int checks = 0;

    ram_resp dut (
        .clk_fast   (clk_fast),
        .reset      (reset),
        .SOF        (SOF),
        .rd_r       (rd_r),
        .wr_r       (wr_r),
        .addrsam_r  (addrsam_r),
        .addrjpeg_r (addrjpeg_r),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .WR_DATAFlag(WR_DATAFlag),
        .busy       (busy),
        .err        (err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two-cycle write, leaving inputs idle afterwards.
    task automatic do_write(input logic [22:0] a, input logic [15:0] d);
        wr_r = 1'b1; addrjpeg_r = a; wr_data = d;
        tick();
        wr_r = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        reset = 1'b1; SOF = 1'b0; rd_r = 1'b0; wr_r = 1'b0;
        addrsam_r = '0; addrjpeg_r = '0; wr_data = '0;
        #12;
        chk("rst_rd_data",  32'(rd_data), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_wrflag",   32'(WR_DATAFlag), 32'h0);
        chk("rst_busy",     32'(busy), 32'h0);
        chk("rst_err",      32'(err), 32'h0);
        chk("rst_rd_count", 32'(rd_count), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Write 0xABCD to 5, then read it back with latency 3
        wr_r = 1'b1; addrjpeg_r = 23'h000005; wr_data = 16'hABCD;
        tick();
        wr_r = 1'b0;
        chk("wr_busy",      32'(busy), 32'h1);
        chk("wr_flag_e0",   32'(WR_DATAFlag), 32'h0);
        chk("wr_count_1",   32'(wr_count), 32'h1);
        tick();
        chk("wr_flag_e1",   32'(WR_DATAFlag), 32'h1);
        chk("wr_idle",      32'(busy), 32'h0);
        tick();
        chk("wr_flag_pulse",32'(WR_DATAFlag), 32'h0);

        rd_r = 1'b1; addrsam_r = 23'h000005;
        tick();
        rd_r = 1'b0;
        chk("rd_busy",      32'(busy), 32'h1);
        chk("rd_count_1",   32'(rd_count), 32'h1);
        chk("rd_vld_e0",    32'(rd_valid), 32'h0);
        tick();
        chk("rd_vld_e1",    32'(rd_valid), 32'h0);
        tick();
        chk("rd_vld_e2",    32'(rd_valid), 32'h0);
        chk("rd_busy_e2",   32'(busy), 32'h1);
        tick();
        chk("rd_vld_e3",    32'(rd_valid), 32'h1);
        chk("rd_data_e3",   32'(rd_data), 32'hABCD);
        chk("rd_idle_e3",   32'(busy), 32'h0);
        tick();
        chk("rd_vld_pulse", 32'(rd_valid), 32'h0);
        chk("rd_data_hold", 32'(rd_data), 32'hABCD);

        // Aliasing: 0x400 and 0x000 share a storage word
        do_write(23'h000400, 16'h1234);
        rd_r = 1'b1; addrsam_r = 23'h000000;
        tick();
        rd_r = 1'b0;
        tick(); tick(); tick();
        chk("alias_vld",    32'(rd_valid), 32'h1);
        chk("alias_data",   32'(rd_data), 32'h1234);
        chk("alias_wr_cnt", 32'(wr_count), 32'h2);
        chk("alias_rd_cnt", 32'(rd_count), 32'h2);

        // Collision: write served, read dropped, err pulse
        rd_r = 1'b1; wr_r = 1'b1; addrsam_r = 23'h000005;
        addrjpeg_r = 23'h000010; wr_data = 16'h5A5A;
        tick();
        rd_r = 1'b0; wr_r = 1'b0;
        chk("coll_err",     32'(err), 32'h1);
        chk("coll_wr_cnt",  32'(wr_count), 32'h3);
        chk("coll_rd_cnt",  32'(rd_count), 32'h2);
        n = 0;
        tick();
        chk("coll_err_pulse", 32'(err), 32'h0);
        chk("coll_wrflag",  32'(WR_DATAFlag), 32'h1);
        repeat (4) begin
            if (rd_valid) n++;
            tick();
        end
        chk("coll_no_rdv",  32'(n), 32'h0);
        rd_r = 1'b1; addrsam_r = 23'h000010;
        tick();
        rd_r = 1'b0;
        tick(); tick(); tick();
        chk("coll_wr_done", 32'(rd_data), 32'h5A5A);
        chk("coll_rdv",     32'(rd_valid), 32'h1);

        // SOF alone clears counters; then busy violation on second read cycle
        SOF = 1'b1;
        tick();
        SOF = 1'b0;
        chk("sof_rd_cnt0",  32'(rd_count), 32'h0);
        chk("sof_wr_cnt0",  32'(wr_count), 32'h0);
        rd_r = 1'b1; addrsam_r = 23'h000005;
        tick();
        tick();
        rd_r = 1'b0;
        chk("busy_err",     32'(err), 32'h1);
        n = 0;
        tick();
        chk("busy_err_pulse", 32'(err), 32'h0);
        repeat (6) begin
            if (rd_valid) begin
                n++;
                chk("busy_rd_data", 32'(rd_data), 32'hABCD);
            end
            tick();
        end
        chk("busy_one_rdv", 32'(n), 32'h1);
        chk("busy_rd_cnt",  32'(rd_count), 32'h1);

        // Seven writes, then SOF with an accepted write
        for (int i = 0; i < 7; i++)
            do_write(23'(32'h20 + i), 16'(i));
        chk("sof_pre_wr7",  32'(wr_count), 32'h7);
        SOF = 1'b1; wr_r = 1'b1; addrjpeg_r = 23'h000030; wr_data = 16'hBEEF;
        tick();
        SOF = 1'b0; wr_r = 1'b0;
        chk("sof_wr_cnt1",  32'(wr_count), 32'h1);
        chk("sof_rd_cnt",   32'(rd_count), 32'h0);
        tick();
        chk("sof_wrflag",   32'(WR_DATAFlag), 32'h1);

        // Reset one cycle into a read: outputs clear, no late rd_valid
        rd_r = 1'b1; addrsam_r = 23'h000030;
        tick();
        rd_r = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_data", 32'(rd_data), 32'h0);
        chk("mid_rst_vld",  32'(rd_valid), 32'h0);
        chk("mid_rst_wcnt", 32'(wr_count), 32'h0);
        tick();
        reset = 1'b0;
        n = 0;
        repeat (6) begin
            tick();
            if (rd_valid) n++;
        end
        chk("mid_rst_no_rdv", 32'(n), 32'h0);

        // Storage survives reset
        rd_r = 1'b1; addrsam_r = 23'h000030;
        tick();
        rd_r = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_vld", 32'(rd_valid), 32'h1);
        chk("post_rst_mem", 32'(rd_data), 32'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
